// File: rtl/uart_tx_framer.sv
// Byte FIFO that collects host writes into packets and streams each committed packet to a UART transmitter.
// Latency: first byte is valid one edge after the edge that accepts the commit (pending, then IDLE->SEND).
// Backpressure: bytes pop only on tx_ready; writes into a full FIFO are dropped with an overflow pulse.
module uart_tx_framer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   input  logic              wr_commit,
   input  logic              tx_ready,
   output logic [7:0]        tx_data_byte,
   output logic              tx_data_valid,
   output logic [9:0]        tx_no_bytes,
   output logic              full,
   output logic              busy,
   output logic              overflow,
   output logic              commit_err
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [9:0]        open_len;   // bytes written since the last accepted commit
   logic [9:0]        pkt_len;    // length of the committed packet waiting to start
   logic [9:0]        remaining;  // bytes still to pop in the current packet
   logic              pending;
   state_t            state;
   state_t            state_nxt;
   logic              push;
   logic              pop;
   logic              load;
   logic              commit_ok;
   logic              commit_rej;

   // Full comes from the occupancy count so a simultaneous push/pop never aliases.
   assign full          = (count == CNT_FULL);
   assign push          = wr_en & ~full;
   // A commit must close at least one byte, counting a byte written in the same cycle.
   assign commit_ok     = wr_commit & ~pending & ((open_len != 10'd0) | push);
   assign commit_rej    = wr_commit & pending;
   assign tx_data_valid = (state == SEND);
   assign tx_data_byte  = mem[rd_ptr];
   assign busy          = pending | (state == SEND);

   // Next-state decode: start a packet when one is pending, pop on each accepted byte.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               load      = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               pop = 1'b1;
               if (remaining == 10'd1) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Storage array; contents need no reset because the read side only exposes written bytes.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Circular pointers and occupancy count.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Packet bookkeeping: open/committed lengths, hand-off to the sender, error pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         open_len    <= '0;
         pkt_len     <= '0;
         remaining   <= '0;
         pending     <= 1'b0;
         tx_no_bytes <= '0;
         overflow    <= 1'b0;
         commit_err  <= 1'b0;
      end else begin
         overflow   <= wr_en & full;
         commit_err <= commit_rej;
         if (commit_ok) begin
            open_len <= '0;
            pkt_len  <= open_len + {9'd0, push};
            pending  <= 1'b1;
         end else if (push) begin
            open_len <= open_len + 10'd1;
         end
         // load needs pending=1 and commit_ok needs pending=0, so these never collide.
         if (load) begin
            pending     <= 1'b0;
            tx_no_bytes <= pkt_len;
            remaining   <= pkt_len;
         end else if (pop) begin
            remaining <= remaining - 10'd1;
         end
      end
   end

endmodule
